// File: rtl/acq_search_controller_pkg.sv
// ---------------------------------------------------------------------------
// acq_search_controller_pkg
// Shared definitions for the acquisition search controller:
//   I2Q2_WIDTH         width of one correlator power result
//   CS_WIDTH           width of a code shift index
//   DOPPLER_INC_WIDTH  width of one Doppler phase increment (two's complement)
//   upd_state_t        states of the peak update engine
//   sub_doppler()      starting Doppler increment of a subchannel
// ---------------------------------------------------------------------------
package acq_search_controller_pkg;

    localparam int I2Q2_WIDTH        = 32;
    localparam int CS_WIDTH          = 12;
    localparam int DOPPLER_INC_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_PEAK,
        ST_UPDATE
    } upd_state_t;

    // Increment of subchannel idx at Doppler step 0, wrapped to the port width.
    function automatic logic [DOPPLER_INC_WIDTH-1:0] sub_doppler(input int start,
                                                                 input int spacing,
                                                                 input int idx);
        return DOPPLER_INC_WIDTH'(start + idx * spacing);
    endfunction

endpackage

// File: rtl/acq_peak_scan.sv
// ---------------------------------------------------------------------------
// acq_peak_scan
// Sequential NUM_SUB-way maximum finder. The packed result vector is captured
// on load; each following step cycle examines one subchannel, lowest index
// first, keeping the first-seen value on ties.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   load              capture data and restart at subchannel 0
//   step              compare the current subchannel
//   data              packed results, subchannel k in slice k
//   max_value         largest value seen so far
//   max_index         subchannel holding max_value
//   last              current subchannel is the final one
// ---------------------------------------------------------------------------
module acq_peak_scan
    import acq_search_controller_pkg::*;
#(
    parameter int NUM_SUB = 3,
    parameter int IDX_W   = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load,
    input  logic                          step,
    input  logic [NUM_SUB*I2Q2_WIDTH-1:0] data,
    output logic [I2Q2_WIDTH-1:0]         max_value,
    output logic [IDX_W-1:0]              max_index,
    output logic                          last
);

    logic [NUM_SUB*I2Q2_WIDTH-1:0] data_q;
    logic [IDX_W-1:0]              idx;
    logic [I2Q2_WIDTH-1:0]         cur;

    assign cur  = data_q[idx*I2Q2_WIDTH +: I2Q2_WIDTH];
    assign last = (idx == IDX_W'(NUM_SUB - 1));

    // Subchannel 0 always seeds the running maximum so results from a
    // previous scan never leak in; later subchannels win only when strictly
    // greater, which gives the lowest index on ties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q    <= '0;
            idx       <= '0;
            max_value <= '0;
            max_index <= '0;
        end else if (load) begin
            data_q <= data;
            idx    <= '0;
        end else if (step) begin
            if ((idx == '0) || (cur > max_value)) begin
                max_value <= cur;
                max_index <= idx;
            end
            if (!last) begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/acq_search_controller.sv
// ---------------------------------------------------------------------------
// acq_search_controller
// Steps a code-shift / Doppler search grid, tracks the strongest correlation
// peak across all subchannels and reports completion / success.
// Ports:
//   clk, global_reset_n        clock, asynchronous active-low reset
//   start_acquisition, abort   control pulses (start wins)
//   threshold                  early-exit level, 0 disables
//   frame_start, accumulation_complete, target_reached, i2q2_valid
//                              feed / tracking strobes
//   i2q2                       packed per-subchannel results
//   doppler, seek_en, code_shift  current bin driven to the correlators
//   busy, acquisition_complete, acquisition_success  search status
//   peak_i2q2, peak_doppler, peak_code_shift        best bin found
// ---------------------------------------------------------------------------
module acq_search_controller
    import acq_search_controller_pkg::*;
#(
    parameter int NUM_SUB          = 3,
    parameter int MAX_CODE_SHIFT   = 2045,
    parameter int NUM_DOPP_STEPS   = 4,
    parameter int DOPP_START       = -1598,
    parameter int DOPP_SUB_SPACING = 1598
) (
    input  logic                                 clk,
    input  logic                                 global_reset_n,
    input  logic                                 start_acquisition,
    input  logic                                 abort,
    input  logic [I2Q2_WIDTH-1:0]                threshold,
    input  logic                                 frame_start,
    input  logic                                 accumulation_complete,
    input  logic                                 target_reached,
    input  logic                                 i2q2_valid,
    input  logic [NUM_SUB*I2Q2_WIDTH-1:0]        i2q2,
    output logic [NUM_SUB*DOPPLER_INC_WIDTH-1:0] doppler,
    output logic                                 seek_en,
    output logic [CS_WIDTH-1:0]                  code_shift,
    output logic                                 busy,
    output logic                                 acquisition_complete,
    output logic                                 acquisition_success,
    output logic [I2Q2_WIDTH-1:0]                peak_i2q2,
    output logic [DOPPLER_INC_WIDTH-1:0]         peak_doppler,
    output logic [CS_WIDTH-1:0]                  peak_code_shift
);

    localparam int DW     = DOPPLER_INC_WIDTH;
    localparam int IDX_W  = (NUM_SUB > 1) ? $clog2(NUM_SUB) : 1;
    localparam int STEP_W = (NUM_DOPP_STEPS > 1) ? $clog2(NUM_DOPP_STEPS) : 1;
    localparam logic [DW-1:0]       STEP_INC  = DW'(NUM_SUB * DOPP_SUB_SPACING);
    localparam logic [CS_WIDTH-1:0] CS_LAST   = CS_WIDTH'(MAX_CODE_SHIFT);
    localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(NUM_DOPP_STEPS - 1);

    logic [STEP_W-1:0]       step_q;
    logic [I2Q2_WIDTH-1:0]   threshold_q;
    logic                    feed_idle;
    logic                    ignore_q;
    logic [CS_WIDTH-1:0]     bin_cs;
    logic [NUM_SUB*DW-1:0]   bin_dopp;
    logic                    bin_ignore;
    logic                    bin_busy;
    logic                    bin_last;

    upd_state_t              state, state_next;
    logic                    scan_load, scan_step, do_update, bin_done;
    logic [I2Q2_WIDTH-1:0]   max_value, new_peak;
    logic [IDX_W-1:0]        max_index;
    logic                    scan_last, last_bin, peak_hit, finish;

    assign last_bin = (code_shift == CS_LAST) && (step_q == STEP_LAST);

    // Success is judged against the peak as it will stand after this cycle.
    assign new_peak = do_update ? max_value : peak_i2q2;
    assign peak_hit = (threshold_q != '0) && (new_peak >= threshold_q);
    assign finish   = (do_update && peak_hit) || (bin_done && bin_last);

    acq_peak_scan #(
        .NUM_SUB (NUM_SUB),
        .IDX_W   (IDX_W)
    ) u_peak_scan (
        .clk       (clk),
        .rst_n     (global_reset_n),
        .load      (scan_load),
        .step      (scan_step),
        .data      (i2q2),
        .max_value (max_value),
        .max_index (max_index),
        .last      (scan_last)
    );

    // Update engine state register.
    always_ff @(posedge clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Update engine: one result set per i2q2_valid, taken only from IDLE so
    // strobes arriving mid-scan are dropped. bin_done marks the end of the
    // processing of a latched bin so the final bin can close the search.
    always_comb begin
        state_next = state;
        scan_load  = 1'b0;
        scan_step  = 1'b0;
        do_update  = 1'b0;
        bin_done   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i2q2_valid && bin_busy && !acquisition_complete) begin
                    scan_load  = 1'b1;
                    state_next = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (bin_ignore) begin
                    state_next = ST_IDLE;
                end else begin
                    scan_step = 1'b1;
                    if (scan_last) begin
                        state_next = ST_PEAK;
                    end
                end
            end
            ST_PEAK: begin
                if (max_value > peak_i2q2) begin
                    state_next = ST_UPDATE;
                end else begin
                    bin_done   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_UPDATE: begin
                do_update  = 1'b1;
                bin_done   = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        if (start_acquisition || abort) begin
            state_next = ST_IDLE;
        end
    end

    // Search sequencing and status. Later statements override earlier ones
    // within a cycle: frame_start beats accumulation_complete on the ignore
    // flag, completion and abort beat stepping, and start beats everything.
    always_ff @(posedge clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            doppler              <= '0;
            seek_en              <= 1'b0;
            code_shift           <= '0;
            busy                 <= 1'b0;
            acquisition_complete <= 1'b0;
            acquisition_success  <= 1'b0;
            peak_i2q2            <= '0;
            peak_doppler         <= '0;
            peak_code_shift      <= '0;
            step_q               <= '0;
            threshold_q          <= '0;
            feed_idle            <= 1'b1;
            ignore_q             <= 1'b0;
            bin_cs               <= '0;
            bin_dopp             <= '0;
            bin_ignore           <= 1'b0;
            bin_busy             <= 1'b0;
            bin_last             <= 1'b0;
        end else if (start_acquisition) begin
            for (int k = 0; k < NUM_SUB; k++) begin
                doppler[k*DW +: DW] <= sub_doppler(DOPP_START, DOPP_SUB_SPACING, k);
            end
            seek_en              <= 1'b1;
            code_shift           <= '0;
            busy                 <= 1'b1;
            acquisition_complete <= 1'b0;
            acquisition_success  <= 1'b0;
            peak_i2q2            <= '0;
            peak_doppler         <= '0;
            peak_code_shift      <= '0;
            step_q               <= '0;
            threshold_q          <= threshold;
            feed_idle            <= 1'b0;
            ignore_q             <= 1'b1;
            bin_busy             <= 1'b0;
            bin_last             <= 1'b0;
        end else begin
            if (target_reached && feed_idle) begin
                seek_en <= 1'b0;
            end
            if (accumulation_complete) begin
                bin_cs     <= code_shift;
                bin_dopp   <= doppler;
                bin_ignore <= ignore_q;
                bin_busy   <= busy;
                feed_idle  <= 1'b1;
                if (busy) begin
                    seek_en <= 1'b1;
                end
                if (ignore_q) begin
                    ignore_q <= 1'b0;
                end else if (busy) begin
                    if (last_bin) begin
                        busy     <= 1'b0;
                        bin_last <= 1'b1;
                    end else if (code_shift == CS_LAST) begin
                        code_shift <= '0;
                        step_q     <= step_q + 1'b1;
                        for (int k = 0; k < NUM_SUB; k++) begin
                            doppler[k*DW +: DW] <= doppler[k*DW +: DW] + STEP_INC;
                        end
                    end else begin
                        code_shift <= code_shift + 1'b1;
                    end
                end
            end
            if (frame_start) begin
                feed_idle <= 1'b0;
                if (seek_en) begin
                    ignore_q <= 1'b1;
                end
            end
            if (do_update) begin
                peak_i2q2       <= max_value;
                peak_code_shift <= bin_cs;
                peak_doppler    <= bin_dopp[max_index*DW +: DW];
            end
            if (finish) begin
                acquisition_complete <= 1'b1;
                acquisition_success  <= peak_hit;
                busy                 <= 1'b0;
                seek_en              <= 1'b0;
                bin_last             <= 1'b0;
            end
            if (abort) begin
                acquisition_complete <= 1'b1;
                acquisition_success  <= 1'b0;
                busy                 <= 1'b0;
                seek_en              <= 1'b0;
                bin_last             <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_acq_search_controller.sv
// ---------------------------------------------------------------------------
// tb_acq_search_controller
// Drives complete searches on a small grid (3 subchannels, 4 shifts, 2 steps)
// with directed and random correlator data. A grid-level model predicts every
// peak improvement and the final verdict; a monitor matches them against the
// DUT whenever its peak or completion outputs change.
// ---------------------------------------------------------------------------
module tb_acq_search_controller;
    import acq_search_controller_pkg::*;

    localparam int NS  = 3;
    localparam int MCS = 3;
    localparam int NDS = 2;
    localparam int DST = -1598;
    localparam int SP  = 1598;
    localparam int NB  = (MCS + 1) * NDS;
    localparam int W   = I2Q2_WIDTH;
    localparam int DW  = DOPPLER_INC_WIDTH;
    localparam int CW  = CS_WIDTH;

    logic              clk = 1'b0;
    logic              global_reset_n = 1'b0;
    logic              start_acquisition = 1'b0;
    logic              abort = 1'b0;
    logic [W-1:0]      threshold = '0;
    logic              frame_start = 1'b0;
    logic              accumulation_complete = 1'b0;
    logic              target_reached = 1'b0;
    logic              i2q2_valid = 1'b0;
    logic [NS*W-1:0]   i2q2 = '0;
    logic [NS*DW-1:0]  doppler;
    logic              seek_en;
    logic [CW-1:0]     code_shift;
    logic              busy;
    logic              acquisition_complete;
    logic              acquisition_success;
    logic [W-1:0]      peak_i2q2;
    logic [DW-1:0]     peak_doppler;
    logic [CW-1:0]     peak_code_shift;

    acq_search_controller #(
        .NUM_SUB          (NS),
        .MAX_CODE_SHIFT   (MCS),
        .NUM_DOPP_STEPS   (NDS),
        .DOPP_START       (DST),
        .DOPP_SUB_SPACING (SP)
    ) dut (
        .clk                   (clk),
        .global_reset_n        (global_reset_n),
        .start_acquisition     (start_acquisition),
        .abort                 (abort),
        .threshold             (threshold),
        .frame_start           (frame_start),
        .accumulation_complete (accumulation_complete),
        .target_reached        (target_reached),
        .i2q2_valid            (i2q2_valid),
        .i2q2                  (i2q2),
        .doppler               (doppler),
        .seek_en               (seek_en),
        .code_shift            (code_shift),
        .busy                  (busy),
        .acquisition_complete  (acquisition_complete),
        .acquisition_success   (acquisition_success),
        .peak_i2q2             (peak_i2q2),
        .peak_doppler          (peak_doppler),
        .peak_code_shift       (peak_code_shift)
    );

    typedef struct {
        logic [W-1:0]  value;
        logic [CW-1:0] cs;
        logic [DW-1:0] dopp;
        int            due;
    } peak_item_t;

    peak_item_t peak_q[$];
    bit         done_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         data [NB][NS];
    logic [W-1:0] model_peak;
    int         model_cs;

    always #5 clk = ~clk;

    // Free-running cycle count used for latency checks.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] exp_dopp(input int idx);
        logic [DW-1:0] r;
        r = DW'(DST + idx * SP);
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Monitor: each strict peak improvement changes peak_i2q2 to a nonzero
    // value, and each search end raises acquisition_complete once.
    logic [W+CW+DW-1:0] prev_peak = '0;
    logic               prev_complete = 1'b0;
    always @(negedge clk) begin
        peak_item_t it;
        if (!global_reset_n) begin
            prev_peak     = '0;
            prev_complete = 1'b0;
        end else begin
            if (({peak_i2q2, peak_code_shift, peak_doppler} != prev_peak) && (peak_i2q2 != '0)) begin
                if (peak_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_peak_update: got %0d, expected no update", peak_i2q2);
                end else begin
                    it = peak_q.pop_front();
                    checkOutput("peak_i2q2", peak_i2q2, it.value);
                    checkOutput("peak_code_shift", peak_code_shift, it.cs);
                    checkOutput("peak_doppler", peak_doppler, it.dopp);
                    checkOutput("update_latency_cycle", cyc, it.due);
                end
            end
            prev_peak = {peak_i2q2, peak_code_shift, peak_doppler};
            if (acquisition_complete && !prev_complete) begin
                if (done_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_complete: got 1, expected 0");
                end else begin
                    checkOutput("acquisition_success", acquisition_success, done_q.pop_front());
                end
            end
            prev_complete = acquisition_complete;
        end
    end

    task automatic pulse(input int which);
        @(posedge clk); #1;
        case (which)
            0: start_acquisition = 1'b1;
            1: abort = 1'b1;
            2: frame_start = 1'b1;
            3: accumulation_complete = 1'b1;
            default: i2q2_valid = 1'b1;
        endcase
        @(posedge clk); #1;
        start_acquisition     = 1'b0;
        abort                 = 1'b0;
        frame_start           = 1'b0;
        accumulation_complete = 1'b0;
        i2q2_valid            = 1'b0;
    endtask

    // One full search over the data[][] grid. Bins are numbered in search
    // order: bin b sits at code shift b%(MCS+1), Doppler step b/(MCS+1).
    task automatic applyStimulus(input logic [W-1:0] thr, input int fs_pct,
                                 input int abort_at, input bit extra_acc);
        bit   ignore, ign, done;
        int   bin, iter, mx, ix, vcyc;
        peak_item_t it;
        threshold = thr;
        pulse(0);
        checkOutput("start_busy", busy, 1);
        checkOutput("start_seek_en", seek_en, 1);
        checkOutput("start_code_shift", code_shift, 0);
        checkOutput("start_peak_i2q2", peak_i2q2, 0);
        checkOutput("start_peak_cs", peak_code_shift, 0);
        checkOutput("start_complete", acquisition_complete, 0);
        for (int k = 0; k < NS; k++)
            checkOutput("start_doppler", doppler[k*DW +: DW], exp_dopp(k));
        ignore = 1'b1;
        done = 1'b0;
        bin = 0;
        iter = 0;
        model_peak = '0;
        model_cs = 0;
        while (!done) begin
            iter++;
            if (iter > 100) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL search_bound: got %0d iterations, expected at most 100", iter);
                break;
            end
            if (bin == abort_at) begin
                done_q.push_back(1'b0);
                pulse(1);
                checkOutput("abort_busy", busy, 0);
                checkOutput("abort_seek_en", seek_en, 0);
                checkOutput("abort_complete", acquisition_complete, 1);
                checkOutput("abort_success", acquisition_success, 0);
                done = 1'b1;
            end else begin
                if (fs_pct > 0 && $urandom_range(0, 99) < fs_pct) begin
                    checkOutput("seek_en_before_frame", seek_en, 1);
                    pulse(2);
                    ignore = 1'b1;
                end
                checkOutput("code_shift", code_shift, model_cs);
                checkOutput("doppler_sub0", doppler[DW-1:0], exp_dopp((bin / (MCS + 1)) * NS));
                pulse(3);
                ign = ignore;
                ignore = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                for (int k = 0; k < NS; k++)
                    i2q2[k*W +: W] = ign ? W'(999) : W'(data[bin][k]);
                i2q2_valid = 1'b1;
                vcyc = cyc;
                @(posedge clk); #1;
                i2q2_valid = 1'b0;
                if (!ign) begin
                    mx = data[bin][0];
                    ix = 0;
                    for (int k = 1; k < NS; k++)
                        if (data[bin][k] > mx) begin
                            mx = data[bin][k];
                            ix = k;
                        end
                    if (W'(mx) > model_peak) begin
                        model_peak = W'(mx);
                        it.value = W'(mx);
                        it.cs    = CW'(bin % (MCS + 1));
                        it.dopp  = exp_dopp((bin / (MCS + 1)) * NS + ix);
                        it.due   = vcyc + NS + 3;
                        peak_q.push_back(it);
                    end
                    if (thr != '0 && model_peak >= thr) begin
                        done_q.push_back(1'b1);
                        done = 1'b1;
                    end else if (bin == NB - 1) begin
                        done_q.push_back(1'b0);
                        done = 1'b1;
                    end
                    if (bin != NB - 1) model_cs = (bin + 1) % (MCS + 1);
                    bin++;
                end
                repeat (10) @(posedge clk);
                #1;
            end
        end
        repeat (12) @(posedge clk);
        #1;
        checkOutput("end_complete", acquisition_complete, 1);
        checkOutput("end_busy", busy, 0);
        checkOutput("end_peak_i2q2", peak_i2q2, model_peak);
        checkOutput("end_code_shift", code_shift, model_cs);
        checkOutput("pending_peak_updates", peak_q.size(), 0);
        checkOutput("pending_completions", done_q.size(), 0);
        if (extra_acc) begin
            pulse(3);
            checkOutput("code_shift_after_complete", code_shift, model_cs);
        end
    endtask

    task automatic clear_data();
        for (int b = 0; b < NB; b++)
            for (int k = 0; k < NS; k++)
                data[b][k] = 0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [W-1:0] thr;
        // Reset state and no self-start after release.
        #3;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_seek_en", seek_en, 0);
        checkOutput("reset_doppler", doppler, 0);
        checkOutput("reset_complete", acquisition_complete, 0);
        repeat (2) @(posedge clk);
        #1 global_reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("no_self_start_busy", busy, 0);

        // Single peak of 500 on sub 2, shift 2, step 1, no threshold.
        clear_data();
        data[6][2] = 500;
        applyStimulus('0, 0, -1, 0);
        checkOutput("dir_peak_value", peak_i2q2, 500);
        checkOutput("dir_peak_cs", peak_code_shift, 2);
        checkOutput("dir_peak_dopp", peak_doppler, exp_dopp(5));
        checkOutput("dir_success", acquisition_success, 0);

        // Same grid with threshold 400: early exit, no further stepping.
        applyStimulus(W'(400), 0, -1, 1);
        checkOutput("early_success", acquisition_success, 1);
        checkOutput("early_seek_en", seek_en, 0);

        // Tie between subs 0 and 1 resolves to sub 0.
        clear_data();
        data[0][0] = 300;
        data[0][1] = 300;
        data[0][2] = 100;
        applyStimulus('0, 0, -1, 0);
        checkOutput("tie_peak_dopp", peak_doppler, exp_dopp(0));

        // Abort at code shift 1 with random data; the next start clears it.
        for (int b = 0; b < NB; b++)
            for (int k = 0; k < NS; k++)
                data[b][k] = $urandom_range(1, 20) * 50;
        applyStimulus('0, 0, 1, 0);

        // Random grids, thresholds and frame_start discards.
        for (int r = 0; r < 4; r++) begin
            for (int b = 0; b < NB; b++)
                for (int k = 0; k < NS; k++)
                    data[b][k] = $urandom_range(0, 20) * 50;
            thr = ($urandom_range(0, 1) == 1) ? W'($urandom_range(600, 1000)) : '0;
            applyStimulus(thr, 30, -1, 1);
        end

        // Reset in the middle of a scan.
        pulse(0);
        pulse(3);
        pulse(3);
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < NS; k++) i2q2[k*W +: W] = W'(700);
        i2q2_valid = 1'b1;
        @(posedge clk); #1;
        i2q2_valid = 1'b0;
        #2 global_reset_n = 1'b0;
        #1;
        checkOutput("midscan_reset_busy", busy, 0);
        checkOutput("midscan_reset_seek_en", seek_en, 0);
        checkOutput("midscan_reset_code_shift", code_shift, 0);
        checkOutput("midscan_reset_doppler", doppler, 0);
        checkOutput("midscan_reset_peak", peak_i2q2, 0);
        @(posedge clk); #1 global_reset_n = 1'b1;
        pulse(4);
        repeat (15) @(posedge clk);
        #1;
        checkOutput("post_reset_peak", peak_i2q2, 0);
        checkOutput("post_reset_busy", busy, 0);
        checkOutput("post_reset_complete", acquisition_complete, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
